// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transceiver: state encoding, data width
// and the helper that sizes the per-bit clock counters.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_CLEANUP
  } uart_state_e;

  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// 8N1 deserializer with a 2-flop input synchronizer; samples each bit at its
// centre, referenced from the start-bit midpoint, and pulses dv on a good stop bit.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte
);

  localparam int            CW       = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_bit;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 dv_q, dv_d;
  logic                 ferr_q, ferr_d;
  logic                 bit_end;

  assign rx_bit  = sync_q[1];
  assign bit_end = (cnt_q == BIT_LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_rx_serial};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        ferr_d = 1'b0;
        if (!rx_bit) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Half-bit recheck rejects glitches and anchors later samples at bit centre.
        if (cnt_q == BIT_MID) begin
          cnt_d   = '0;
          state_d = rx_bit ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_bit;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_CLEANUP;
          if (rx_bit) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CLEANUP: begin
        // After a framing error, hold off until the line idles so the low
        // stop bit is not mistaken for a new start bit.
        if (!ferr_q || rx_bit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_rx_dv   = dv_q;
  assign o_rx_byte = byte_q;

endmodule

// File: rtl/uart_tx_fsm.sv
// 8N1 serializer: accepts a byte while idle, then drives start, data (LSB first)
// and stop bits for CLKS_PER_BIT clocks each; pulses done as the stop bit ends.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_tx_dv,
  input  logic [DATA_BITS-1:0] i_tx_byte,
  output logic                 o_tx_active,
  output logic                 o_tx_serial,
  output logic                 o_tx_done
);

  localparam int            CW       = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == BIT_LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    active_d = active_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (i_tx_dv) begin
          byte_d   = i_tx_byte;
          active_d = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        // done and active change together so the host sees one clean handoff
        if (bit_end) begin
          cnt_d    = '0;
          done_d   = 1'b1;
          active_d = 1'b0;
          state_d  = ST_CLEANUP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CLEANUP: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Line level decoded from state so an async reset returns it high at once.
  always_comb begin
    o_tx_serial = 1'b1;
    case (state_q)
      ST_START: o_tx_serial = 1'b0;
      ST_DATA:  o_tx_serial = byte_q[idx_q];
      default:  o_tx_serial = 1'b1;
    endcase
  end

  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;

endmodule

// File: rtl/uart_transceiver.sv
// 8N1 UART with independent transmit and receive paths on one clock; the bit
// rate is CLKS_PER_BIT clocks per serial bit.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_tx_dv,
  input  logic [DATA_BITS-1:0] i_tx_byte,
  output logic                 o_tx_active,
  output logic                 o_tx_serial,
  output logic                 o_tx_done,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte
);

  uart_tx_fsm #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_tx_dv    (i_tx_dv),
    .i_tx_byte  (i_tx_byte),
    .o_tx_active(o_tx_active),
    .o_tx_serial(o_tx_serial),
    .o_tx_done  (o_tx_done)
  );

  uart_rx_fsm #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_rx_serial(i_rx_serial),
    .o_rx_dv    (o_rx_dv),
    .o_rx_byte  (o_rx_byte)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed plus randomized bench for uart_transceiver at 10 MHz / 87 clocks per bit.
`timescale 1ns/1ps
module tb_uart_transceiver;

  localparam int CPB = 87;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_drv = 1'b1;
  logic       loopback = 1'b0;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] rx_hist[$];
  int         rx_cyc[$];

  assign rx_serial = loopback ? tx_serial : rx_drv;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_tx_dv    (tx_dv),
    .i_tx_byte  (tx_byte),
    .o_tx_active(tx_active),
    .o_tx_serial(tx_serial),
    .o_tx_done  (tx_done),
    .i_rx_serial(rx_serial),
    .o_rx_dv    (rx_dv),
    .o_rx_byte  (rx_byte)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_dv === 1'b1) begin
      rx_hist.push_back(rx_byte);
      rx_cyc.push_back(cyc);
    end
    if (tx_done === 1'b1) done_cnt++;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 20 ms");
    $fatal(1, "watchdog expired");
  end

  // Expected line level of frame bit i (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input int stretch, input logic stop_lvl);
    rx_drv = 1'b0;
    step(CPB + stretch);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      step(CPB);
    end
    rx_drv = stop_lvl;
    step(CPB);
    rx_drv = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    tx_byte = b;
    tx_dv   = 1'b1;
    step(1);
    tx_dv   = 1'b0;
    step(10 * CPB + 2);
  endtask

  initial begin
    int lvl_ok[10];
    int act_ok, early_done, late_act, d0, nd, t0, good;
    logic [7:0] b;
    logic [7:0] exp_q[$];

    // Reset state
    step(3);
    chk("rst_tx_serial", 32'(tx_serial), 32'd1);
    chk("rst_tx_active", 32'(tx_active), 32'd0);
    chk("rst_tx_done",   32'(tx_done),   32'd0);
    chk("rst_rx_dv",     32'(rx_dv),     32'd0);
    chk("rst_rx_byte",   32'(rx_byte),   32'h00);
    rst_n = 1'b1;
    step(5);

    // TX 0xAB, dv held for 5 clocks, byte changed mid-frame
    d0 = done_cnt;
    foreach (lvl_ok[i]) lvl_ok[i] = 0;
    act_ok = 0;
    early_done = 0;
    tx_byte = 8'hAB;
    tx_dv = 1'b1;
    step(1);
    for (int c = 0; c < 10 * CPB; c++) begin
      if (tx_serial === frame_bit(8'hAB, c / CPB)) lvl_ok[c / CPB]++;
      if (tx_active === 1'b1) act_ok++;
      if (tx_done !== 1'b0) early_done++;
      if (c == 4) tx_dv = 1'b0;
      if (c == 10) tx_byte = 8'($urandom);
      step(1);
    end
    for (int i = 0; i < 10; i++) chk($sformatf("tx_ab_bit%0d_clocks", i), 32'(lvl_ok[i]), 32'(CPB));
    chk("tx_ab_active_clocks", 32'(act_ok), 32'(10 * CPB));
    chk("tx_ab_done_early", 32'(early_done), 32'd0);
    chk("tx_ab_done_pulse", 32'(tx_done), 32'd1);
    chk("tx_ab_active_end", 32'(tx_active), 32'd0);
    chk("tx_ab_serial_idle", 32'(tx_serial), 32'd1);
    step(1);
    chk("tx_ab_done_one_cycle", 32'(tx_done), 32'd0);
    late_act = 0;
    for (int c = 0; c < 1000; c++) begin
      if (tx_active !== 1'b0) late_act++;
      step(1);
    end
    chk("tx_ab_no_second_frame", 32'(late_act), 32'd0);
    chk("tx_ab_done_count", 32'(done_cnt - d0), 32'd1);

    // RX 0x3F with start bit stretched by 1000 ns
    loopback = 1'b0;
    nd = rx_hist.size();
    t0 = cyc;
    send_rx(8'h3F, 10, 1'b1);
    step(20);
    chk("rx_3f_dv_count", 32'(rx_hist.size() - nd), 32'd1);
    if (rx_hist.size() > nd) begin
      chk("rx_3f_byte", 32'(rx_hist[nd]), 32'h3F);
      chk("rx_3f_in_stop_bit",
          32'((rx_cyc[nd] >= t0 + 9 * CPB + 10) && (rx_cyc[nd] <= t0 + 10 * CPB + 14)), 32'd1);
    end
    chk("rx_3f_held", 32'(rx_byte), 32'h3F);

    // RX glitch on idle line
    nd = rx_hist.size();
    rx_drv = 1'b0;
    step(20);
    rx_drv = 1'b1;
    step(200);
    chk("rx_glitch_no_dv", 32'(rx_hist.size() - nd), 32'd0);
    chk("rx_glitch_byte_kept", 32'(rx_byte), 32'h3F);

    // RX framing error then a good frame
    send_rx(8'h55, 0, 1'b0);
    step(50);
    chk("rx_ferr_no_dv", 32'(rx_hist.size() - nd), 32'd0);
    chk("rx_ferr_byte_kept", 32'(rx_byte), 32'h3F);
    send_rx(8'hC3, 0, 1'b1);
    step(20);
    chk("rx_c3_dv_count", 32'(rx_hist.size() - nd), 32'd1);
    chk("rx_c3_byte", 32'(rx_byte), 32'hC3);

    // Reset during TX and RX data bit 3 (loopback)
    loopback = 1'b1;
    nd = rx_hist.size();
    d0 = done_cnt;
    tx_byte = 8'hF0;
    tx_dv = 1'b1;
    step(1);
    tx_dv = 1'b0;
    step(4 * CPB + 40);
    chk("rst_mid_bit3_level", 32'(tx_serial), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_serial_high", 32'(tx_serial), 32'd1);
    chk("rst_mid_active_low", 32'(tx_active), 32'd0);
    step(5);
    rst_n = 1'b1;
    step(1000);
    chk("rst_mid_no_dv", 32'(rx_hist.size() - nd), 32'd0);
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    send_tx(8'h81);
    step(20);
    chk("rst_after_dv_count", 32'(rx_hist.size() - nd), 32'd1);
    chk("rst_after_byte", 32'(rx_byte), 32'h81);

    // Back-to-back loopback with dv held high across two frames
    nd = rx_hist.size();
    tx_byte = 8'h00;
    tx_dv = 1'b1;
    step(1);
    tx_byte = 8'hFF;
    good = 0;
    for (int i = 0; i < 2000 && good == 0; i++) begin
      step(1);
      if (tx_active === 1'b0) good = 1;
    end
    for (int i = 0; i < 10 && good == 1; i++) begin
      step(1);
      if (tx_active === 1'b1) good = 2;
    end
    tx_dv = 1'b0;
    chk("b2b_second_accept", 32'(good), 32'd2);
    step(1000);
    chk("b2b_dv_count", 32'(rx_hist.size() - nd), 32'd2);
    if (rx_hist.size() >= nd + 2) begin
      chk("b2b_first_byte", 32'(rx_hist[nd]), 32'h00);
      chk("b2b_second_byte", 32'(rx_hist[nd + 1]), 32'hFF);
      chk("b2b_dv_spacing", 32'(rx_cyc[nd + 1] - rx_cyc[nd]), 32'(10 * CPB + 2));
    end

    // Randomized frames, loopback or directly driven with random start stretch
    nd = rx_hist.size();
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      if ($urandom_range(0, 1) == 0) begin
        loopback = 1'b1;
        send_tx(b);
      end else begin
        loopback = 1'b0;
        send_rx(b, int'($urandom_range(0, 30)), 1'b1);
      end
      step(int'($urandom_range(2, 40)));
    end
    step(50);
    chk("rand_dv_count", 32'(rx_hist.size() - nd), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && nd + k < rx_hist.size(); k++)
      chk($sformatf("rand_byte%0d", k), 32'(rx_hist[nd + k]), 32'(exp_q[k]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
